// File: rtl/boron_pkg.sv
// Shared types and Boron default sizing for the block-shuffle datapath.
package boron_pkg;

  // Control FSM for the iterative shuffle stage
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rotation direction select
  localparam logic MODE_ENC = 1'b0;  // rotate left
  localparam logic MODE_DEC = 1'b1;  // rotate right

  // Boron cipher defaults
  localparam int BORON_BLOCK_W    = 64;
  localparam int BORON_WORD_W     = 16;
  localparam int BORON_ROT        = 8;
  localparam int BORON_MAX_ROUNDS = 25;
  localparam int BORON_CNT_W      = 5;

endpackage

// File: rtl/block_shuffle_round.sv
// One combinational shuffle round: every WORD_W word of the block is rotated
// by ROT bits independently (left for encrypt, right for decrypt).
module block_shuffle_round
  import boron_pkg::*;
#(
  parameter int DATA_W = BORON_BLOCK_W,
  parameter int WORD_W = BORON_WORD_W,
  parameter int ROT    = BORON_ROT
) (
  input  logic              mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int NUM_WORDS = DATA_W / WORD_W;

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] w_rotl;
    logic [WORD_W-1:0] w_rotr;

    assign w      = data_i[i*WORD_W +: WORD_W];
    assign w_rotl = {w[WORD_W-ROT-1:0], w[WORD_W-1:WORD_W-ROT]};
    assign w_rotr = {w[ROT-1:0], w[WORD_W-1:ROT]};
    assign data_o[i*WORD_W +: WORD_W] = (mode_i == MODE_DEC) ? w_rotr : w_rotl;
  end

endmodule

// File: rtl/block_shuffle_iter.sv
// Iterative block shuffle: accepts a block, applies one shuffle round per
// clock for a run-time round count, then holds the result until taken.
module block_shuffle_iter
  import boron_pkg::*;
#(
  parameter int DATA_W     = BORON_BLOCK_W,
  parameter int WORD_W     = BORON_WORD_W,
  parameter int ROT        = BORON_ROT,
  parameter int MAX_ROUNDS = BORON_MAX_ROUNDS,
  parameter int CNT_W      = BORON_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  rounds_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

  // Reject parameter sets the datapath cannot implement
  if ((DATA_W % WORD_W) != 0 || ROT <= 0 || ROT >= WORD_W ||
      (2 ** CNT_W) <= MAX_ROUNDS) begin : g_param_check
    $fatal(1, "block_shuffle_iter: illegal parameter combination");
  end

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                mode_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_d;
  logic [CNT_W-1:0]    rounds_clamped;

  // Oversized round requests saturate at the cipher's maximum
  assign rounds_clamped = (rounds_i > CNT_W'(MAX_ROUNDS)) ? CNT_W'(MAX_ROUNDS) : rounds_i;

  block_shuffle_round #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W),
    .ROT    (ROT)
  ) u_round (
    .mode_i (mode_q),
    .data_i (data_q),
    .data_o (data_d)
  );

  // Control FSM, round counter and data register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= MODE_ENC;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            data_q <= data_i;
            mode_q <= mode_i;
            cnt_q  <= rounds_clamped;
            if (rounds_clamped == '0) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_block_shuffle_iter.sv
// Directed and random checks of block_shuffle_iter at ROT=8 and ROT=4.
module tb_block_shuffle_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [4:0]  rounds_i = '0;
  logic [63:0] data_i = '0;
  logic        ready_i = 1'b0;
  logic        ready8, valid8, ready4, valid4;
  logic [63:0] data8, data4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  block_shuffle_iter #(.DATA_W(64), .WORD_W(16), .ROT(8), .MAX_ROUNDS(25), .CNT_W(5)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready8), .data_i(data_i),
    .mode_i(mode_i), .rounds_i(rounds_i), .valid_o(valid8), .ready_i(ready_i), .data_o(data8));

  block_shuffle_iter #(.DATA_W(64), .WORD_W(16), .ROT(4), .MAX_ROUNDS(25), .CNT_W(5)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready4), .data_i(data_i),
    .mode_i(mode_i), .rounds_i(rounds_i), .valid_o(valid4), .ready_i(ready_i), .data_o(data4));

  typedef struct {
    logic        sel4;
    logic [63:0] din;
    logic        mode;
    logic [4:0]  rounds;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bit-level reference: each 16-bit word rotated by rot per round
  function automatic logic [63:0] model(input logic [63:0] d, input logic mode,
                                        input int rounds, input int rot);
    logic [63:0] cur, nxt;
    int r;
    r = (rounds > 25) ? 25 : rounds;
    cur = d;
    for (int k = 0; k < r; k++) begin
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 16; b++)
          if (mode == 1'b0) nxt[w*16 + (b + rot) % 16] = cur[w*16 + b];
          else              nxt[w*16 + b] = cur[w*16 + (b + rot) % 16];
      cur = nxt;
    end
    return cur;
  endfunction

  // Submit one block, wait for the result, then pop it. Called at posedge+1.
  task automatic run_block(input logic [63:0] din, input logic mode, input logic [4:0] rounds,
                           output logic [63:0] r8, output logic [63:0] r4, output int lat);
    valid_i  = 1'b1;
    data_i   = din;
    mode_i   = mode;
    rounds_i = rounds;
    @(posedge clk); #1;
    valid_i  = 1'b0;
    data_i   = {$urandom, $urandom};
    mode_i   = ~mode;
    rounds_i = 5'($urandom_range(0, 31));
    lat = 1;
    while (!valid8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    r8 = data8;
    r4 = data4;
    chk("valid4_lockstep", {63'b0, valid4}, {63'b0, valid8});
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("pop_valid", {63'b0, valid8}, 64'd0);
    chk("pop_ready", {63'b0, ready8}, 64'd1);
  endtask

  initial begin
    logic [63:0] r8, r4, r8b, r4b, din;
    logic        m;
    logic [4:0]  rn;
    int          lat, lat2, rc;

    vecs[0] = '{1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd1,  64'h2301_6745_AB89_EFCD, 2};
    vecs[1] = '{1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd2,  64'h0123_4567_89AB_CDEF, 3};
    vecs[2] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd1,  64'h1230_5674_9AB8_DEFC, 2};
    vecs[3] = '{1'b1, 64'h1230_5674_9AB8_DEFC, 1'b1, 5'd1,  64'h0123_4567_89AB_CDEF, 2};
    vecs[4] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd3,  64'h3012_7456_B89A_FCDE, 4};
    vecs[5] = '{1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 5'd0,  64'hDEAD_BEEF_CAFE_F00D, 1};
    vecs[6] = '{1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd31, 64'h2301_6745_AB89_EFCD, 26};
    vecs[7] = '{1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd25, 64'h2301_6745_AB89_EFCD, 26};
    vecs[8] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd25, 64'h3012_7456_B89A_FCDE, 26};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid8", {63'b0, valid8}, 64'd0);
    chk("rst_ready8", {63'b0, ready8}, 64'd1);
    chk("rst_data8", data8, 64'd0);
    chk("rst_ready4", {63'b0, ready4}, 64'd1);
    chk("rst_data4", data4, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_block(vecs[i].din, vecs[i].mode, vecs[i].rounds, r8, r4, lat);
      chk($sformatf("vec%0d_data", i), vecs[i].sel4 ? r4 : r8, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure in DONE with an ignored valid_i pulse
    valid_i = 1'b1; data_i = 64'h0123_4567_89AB_CDEF; mode_i = 1'b0; rounds_i = 5'd1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid8 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      valid_i  = (i == 2);
      data_i   = 64'hFFFF_0000_FFFF_0000;
      rounds_i = 5'd0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("bp_valid", {63'b0, valid8}, 64'd1);
      chk("bp_data", data8, 64'h2301_6745_AB89_EFCD);
      chk("bp_ready", {63'b0, ready8}, 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp_release_valid", {63'b0, valid8}, 64'd0);
    chk("bp_release_ready", {63'b0, ready8}, 64'd1);
    @(posedge clk); #1;
    chk("bp_no_late_accept", {63'b0, valid8}, 64'd0);

    // Reset on the third RUN edge discards the block
    valid_i = 1'b1; data_i = 64'h0123_4567_89AB_CDEF; mode_i = 1'b0; rounds_i = 5'd25;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {63'b0, valid8}, 64'd0);
    chk("mid_rst_ready", {63'b0, ready8}, 64'd1);
    chk("mid_rst_data", data8, 64'd0);
    run_block(vecs[0].din, vecs[0].mode, vecs[0].rounds, r8, r4, lat);
    chk("post_rst_data", r8, vecs[0].exp);
    chk("post_rst_latency", 64'(lat), 64'd2);

    // Random regression with encrypt/decrypt round trip
    for (int n = 0; n < 1000; n++) begin
      din = {$urandom, $urandom};
      m   = 1'($urandom_range(0, 1));
      rn  = 5'($urandom_range(0, 31));
      rc  = (rn > 25) ? 25 : int'(rn);
      run_block(din, m, rn, r8, r4, lat);
      chk("rnd_data8", r8, model(din, m, int'(rn), 8));
      chk("rnd_data4", r4, model(din, m, int'(rn), 4));
      chk("rnd_latency", 64'(lat), 64'(rc + 1));
      run_block(r8, ~m, rn, r8b, r4b, lat2);
      chk("rnd_roundtrip8", r8b, din);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
